ising_run_ctrl: RTL and testbench

ISING_RUN_CTRL -- requirements
Module: ising_run_ctrl

---
 rtl/ising_run_ctrl.sv | 90 +++++++++
 tb/tb_ising_run_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: run sequencer for an oscillator-based Ising machine.
//   clk, axi_rstn    : clock and asynchronous active-low reset
//   start/abort      : one-cycle run request / cancel
//   run_cycles       : RUN length in clk cycles, sampled on accepted start (0 runs as 1)
//   wr_*/mat_*       : host weight writes, forwarded to the matrix only while idle
//   ising_rstn       : oscillator-array reset, released during RUN and SAMPLE
//   bot_row          : asynchronous phase outputs, synchronized and captured in SAMPLE
//   busy/done/aborted/result : run status and captured spin vector
module ising_run_ctrl #(
  parameter int N          = 8,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             wr_valid,
  input  logic [31:0]      wr_addr_in,
  input  logic [31:0]      wdata_in,
  output logic             wr_ready,
  output logic             mat_wready,
  output logic             mat_wr_match,
  output logic [31:0]      mat_wr_addr,
  output logic [31:0]      mat_wdata,
  output logic             ising_rstn,
  input  logic [N-1:0]     bot_row,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [N-1:0]     result
);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, SAMPLE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, len;
  logic [N-1:0] sync1, sync2;
  logic take, capture, wr_acc;
  assign take    = state == IDLE && start && !abort;
  assign capture = state == SAMPLE && !abort;
  assign wr_acc  = wr_valid && wr_ready;
  always_ff @(posedge clk or negedge axi_rstn)
    if (!axi_rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = take ? HOLD : IDLE;
    else if (abort) state_nx = IDLE;
    else if (state == HOLD) state_nx = cnt == CNT_W'(RST_CYCLES - 1) ? RUN : HOLD;
    else if (state == RUN) state_nx = cnt == len - CNT_W'(1) ? SAMPLE : RUN;
    else state_nx = IDLE;
  end
  always_comb begin
    busy     = state != IDLE;
    wr_ready = state == IDLE;
  end
  // cnt restarts on every state change, so it counts cycles spent in the current state
  always_ff @(posedge clk or negedge axi_rstn)
    if (!axi_rstn) begin
      cnt        <= '0;
      len        <= '0;
      ising_rstn <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      result     <= '0;
      sync1      <= '0;
      sync2      <= '0;
    end else begin
      cnt        <= state_nx != state ? '0 : cnt + CNT_W'(1);
      len        <= take ? (run_cycles == '0 ? CNT_W'(1) : run_cycles) : len;
      ising_rstn <= state_nx == RUN || state_nx == SAMPLE;
      done       <= capture;
      aborted    <= state != IDLE && abort;
      result     <= capture ? sync2 : result;
      sync1      <= bot_row;
      sync2      <= sync1;
    end
  always_ff @(posedge clk or negedge axi_rstn)
    if (!axi_rstn) begin
      mat_wready   <= 1'b0;
      mat_wr_match <= 1'b0;
      mat_wr_addr  <= '0;
      mat_wdata    <= '0;
    end else begin
      mat_wready   <= wr_acc;
      mat_wr_match <= wr_acc;
      mat_wr_addr  <= wr_acc ? wr_addr_in : mat_wr_addr;
      mat_wdata    <= wr_acc ? wdata_in : mat_wdata;
    end
endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb_ising_run_ctrl: scoreboard bench for ising_run_ctrl with directed runs.
module tb_ising_run_ctrl;
  logic        clk = 1'b0;
  logic        axi_rstn, start, abort, wr_valid;
  logic [31:0] run_cycles, wr_addr_in, wdata_in;
  logic        wr_ready, mat_wready, mat_wr_match, ising_rstn, busy, done, aborted;
  logic [31:0] mat_wr_addr, mat_wdata;
  logic [7:0]  bot_row, result;
  int tests = 0, fails = 0, cyc = 0;
  int q_done_cyc[$], q_ab_cyc[$], q_wr_cyc[$];
  logic [7:0]  q_done_res[$];
  logic [31:0] q_wr_a[$], q_wr_d[$];

  ising_run_ctrl #(.N(8), .RST_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .start(start), .abort(abort), .run_cycles(run_cycles),
    .wr_valid(wr_valid), .wr_addr_in(wr_addr_in), .wdata_in(wdata_in), .wr_ready(wr_ready),
    .mat_wready(mat_wready), .mat_wr_match(mat_wr_match), .mat_wr_addr(mat_wr_addr),
    .mat_wdata(mat_wdata), .ising_rstn(ising_rstn), .bot_row(bot_row), .busy(busy),
    .done(done), .aborted(aborted), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // monitor: pops the matching queue whenever the DUT presents an event
  always @(negedge clk) begin
    if (done) begin
      if (q_done_cyc.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_cycle", 64'(cyc), 64'(q_done_cyc.pop_front()));
        chk("done_result", 64'(result), 64'(q_done_res.pop_front()));
      end
    end
    if (aborted) begin
      if (q_ab_cyc.size() == 0) chk("unexpected_aborted", 1, 0);
      else chk("aborted_cycle", 64'(cyc), 64'(q_ab_cyc.pop_front()));
    end
    if (mat_wready) begin
      if (q_wr_cyc.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("wr_cycle", 64'(cyc), 64'(q_wr_cyc.pop_front()));
        chk("wr_addr", 64'(mat_wr_addr), 64'(q_wr_a.pop_front()));
        chk("wr_data", 64'(mat_wdata), 64'(q_wr_d.pop_front()));
        chk("wr_match", 64'(mat_wr_match), 1);
      end
    end
  end

  // start a run at the current negedge; done is expected len+6 cycles later
  task automatic go(input logic [31:0] rc, input logic [7:0] res, input bit push, output int c);
    int len;
    len = rc == 0 ? 1 : int'(rc);
    start = 1'b1;
    run_cycles = rc;
    c = cyc;
    if (push) begin
      q_done_cyc.push_back(c + len + 6);
      q_done_res.push_back(res);
    end
    tick();
    start = 1'b0;
  endtask

  // count ising_rstn low cycles before first high, and high cycles, over n samples
  task automatic watch(input int n, input int pulse_at, output int lows, output int highs);
    bit seen = 0;
    lows = 0;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      if (ising_rstn) begin
        seen = 1;
        highs++;
      end else if (!seen) lows++;
      if (i < n - 1) begin
        start = (i == pulse_at);
        tick();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int c, lo, hi;
    bit got;
    axi_rstn = 0; start = 0; abort = 0; wr_valid = 0;
    run_cycles = 0; wr_addr_in = 0; wdata_in = 0; bot_row = 8'h00;
    tick(3);
    chk("rst_ising_rstn", ising_rstn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_mat_addr", mat_wr_addr, 0);
    chk("rst_wr_ready", wr_ready, 1);
    axi_rstn = 1;
    tick(2);
    // nominal run of 10 cycles with a stray start mid-RUN
    bot_row = 8'hA5;
    tick(3);
    go(10, 8'hA5, 1, c);
    watch(16, 6, lo, hi);
    chk("run10_hold_len", lo, 4);
    chk("run10_high_len", hi, 11);
    chk("run10_done_at_16", done, 1);
    tick(3);
    // run_cycles = 0 behaves as one RUN cycle
    bot_row = 8'h3C;
    tick(3);
    go(0, 8'h3C, 1, c);
    watch(7, -1, lo, hi);
    chk("run0_hold_len", lo, 4);
    chk("run0_high_len", hi, 2);
    chk("run0_done", done, 1);
    tick(3);
    // abort on third RUN cycle
    bot_row = 8'h0F;
    tick(3);
    go(10, 8'h00, 0, c);
    tick(6);
    abort = 1'b1;
    q_ab_cyc.push_back(c + 8);
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_ising_rstn", ising_rstn, 0);
    chk("abort_result_kept", result, 8'h3C);
    tick(20);
    chk("abort_result_later", result, 8'h3C);
    // write held during a run is taken only once idle
    go(5, 8'h0F, 1, c);
    wr_valid = 1'b1; wr_addr_in = 32'h1234_5678; wdata_in = 32'hCAFE_F00D;
    tick();
    chk("wr_blocked_busy", wr_ready, 0);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (wr_ready) begin
        got = 1;
        chk("wr_first_idle_cycle", 64'(cyc), 64'(c + 11));
        q_wr_cyc.push_back(cyc + 1);
        q_wr_a.push_back(wr_addr_in);
        q_wr_d.push_back(wdata_in);
      end
      tick();
    end
    chk("wr_ready_seen", got, 1);
    wr_valid = 1'b0;
    tick(3);
    chk("wr_addr_stable", mat_wr_addr, 32'h1234_5678);
    // write and start in the same idle cycle
    wr_valid = 1'b1; wr_addr_in = 32'h0000_00AA; wdata_in = 32'h0000_00BB;
    q_wr_cyc.push_back(cyc + 1);
    q_wr_a.push_back(32'hAA);
    q_wr_d.push_back(32'hBB);
    go(2, 8'h0F, 1, c);
    wr_valid = 1'b0;
    chk("wr_start_ising_low", ising_rstn, 0);
    chk("wr_start_issued", mat_wready, 1);
    chk("wr_start_busy", busy, 1);
    tick(10);
    // start with abort in the same idle cycle is dropped
    start = 1'b1; abort = 1'b1; run_cycles = 3;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_aborted", aborted, 0);
    tick(10);
    // reset mid-RUN, then a clean run
    bot_row = 8'h5A;
    go(20, 8'h00, 0, c);
    tick(8);
    chk("pre_reset_ising_rstn", ising_rstn, 1);
    axi_rstn = 1'b0;
    #1;
    chk("mid_rst_ising_rstn", ising_rstn, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_mat_addr", mat_wr_addr, 0);
    chk("mid_rst_mat_data", mat_wdata, 0);
    chk("mid_rst_wr_ready", wr_ready, 1);
    tick();
    axi_rstn = 1'b1;
    bot_row = 8'hC3;
    tick(3);
    go(3, 8'hC3, 1, c);
    tick(9);
    chk("post_rst_result", result, 8'hC3);
    tick(5);
    chk("pending_done", q_done_cyc.size(), 0);
    chk("pending_aborted", q_ab_cyc.size(), 0);
    chk("pending_write", q_wr_cyc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
